// File: rtl/led7_scan_mux_if.sv
// rtl/led7_scan_mux_if.sv - application-side bundle for the led7 scan driver
// Purpose: groups the display data inputs, the load strobe and the led7 pin
//          outputs of led7_scan_mux into one interface.
// Signals:
//   digits_i   [4*NUM_DIGITS] hex nibble per digit, digit 0 rightmost
//   digit_en_i [NUM_DIGITS]   1 = digit shown
//   dp_i       [NUM_DIGITS]   1 = decimal point lit
//   blink_i    [NUM_DIGITS]   1 = digit blinks
//   load_i                    capture the four vectors above into the shadow set
//   frame_o                   one-cycle pulse when the digit 0 slot starts
//   led7_seg_o [8]            active-low segments, bit7=a .. bit1=g, bit0=dp
//   led7_an_o  [NUM_DIGITS]   active-low anodes, one-hot-low
// Modports: master = application side, slave = led7_scan_mux.
interface led7_scan_mux_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] digits_i;
  logic [NUM_DIGITS-1:0]   digit_en_i;
  logic [NUM_DIGITS-1:0]   dp_i;
  logic [NUM_DIGITS-1:0]   blink_i;
  logic                    load_i;
  logic                    frame_o;
  logic [7:0]              led7_seg_o;
  logic [NUM_DIGITS-1:0]   led7_an_o;

  modport master (
    output digits_i, digit_en_i, dp_i, blink_i, load_i,
    input  frame_o, led7_seg_o, led7_an_o
  );

  modport slave (
    input  digits_i, digit_en_i, dp_i, blink_i, load_i,
    output frame_o, led7_seg_o, led7_an_o
  );
endinterface

// File: rtl/led7_scan_mux.sv
// rtl/led7_scan_mux.sv - multiplexed common-anode 7-segment scan driver
// Purpose: scans NUM_DIGITS digits one slot every PRESCALE clocks, decoding
//          hex nibbles with per-digit enable, decimal point and blink.
//          Inputs are double-buffered: load_i fills a shadow set, which is
//          committed to the active set only at a frame boundary, so a frame
//          never shows a mix of old and new data.
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   bus     led7_scan_mux_if.slave (data inputs, load strobe, led7 pins)
// Parameters: NUM_DIGITS (1..16), PRESCALE (>=1), BLINK_DIV (>=1)
// Optional: define LED7_LZ_BLANK_EN to blank leading zeros (digit 0 is never
//           blanked, decimal points stay honoured).
module led7_scan_mux #(
  parameter int NUM_DIGITS = 8,
  parameter int PRESCALE   = 100000,
  parameter int BLINK_DIV  = 64
) (
  input logic            clk_i,
  input logic            rst_ni,
  led7_scan_mux_if.slave bus
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int PW = (PRESCALE > 1)   ? $clog2(PRESCALE)   : 1;
  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_DIV > 1)  ? $clog2(BLINK_DIV)  : 1;

  localparam logic [PW-1:0]         PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [SW-1:0]         SCAN_LAST  = SW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0]         BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE     = NUM_DIGITS'(1);

  // Active-low segment patterns {a,b,c,d,e,f,g,dp}; dp is patched in later.
  function automatic logic [7:0] hex_seg(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0: s = 8'h03;
      4'h1: s = 8'h9F;
      4'h2: s = 8'h25;
      4'h3: s = 8'h0D;
      4'h4: s = 8'h99;
      4'h5: s = 8'h49;
      4'h6: s = 8'h41;
      4'h7: s = 8'h1F;
      4'h8: s = 8'h01;
      4'h9: s = 8'h09;
      4'hA: s = 8'h11;
      4'hB: s = 8'hC1;
      4'hC: s = 8'h63;
      4'hD: s = 8'h85;
      4'hE: s = 8'h61;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

  // State
  logic [PW-1:0]         presc_q, presc_d;
  logic [SW-1:0]         scan_q, scan_d;
  logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
  logic                  blink_ph_q, blink_ph_d;
  logic [DW-1:0]         sh_dig_q, sh_dig_d;
  logic [NUM_DIGITS-1:0] sh_en_q, sh_en_d;
  logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0] sh_bl_q, sh_bl_d;
  logic [DW-1:0]         act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0] act_en_q, act_en_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0] act_bl_q, act_bl_d;
  logic                  pending_q, pending_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_q, frame_d;

  // Strobes
  logic tick;
  logic boundary;
  logic commit;

  // Data the current slot is decoded from: on a committing boundary the
  // shadow set is used directly so slot 0 already shows the new frame.
  logic [DW-1:0]         src_dig;
  logic [NUM_DIGITS-1:0] src_en;
  logic [NUM_DIGITS-1:0] src_dp;
  logic [NUM_DIGITS-1:0] src_bl;

  logic [NUM_DIGITS-1:0] supp;

  logic [3:0] sel_nib;
  logic       sel_en;
  logic       sel_dp;
  logic       sel_bl;
  logic       sel_supp;
  logic [7:0] sel_hex;
  logic [7:0] slot_seg;

  always_comb begin
    tick     = (presc_q == PRESC_LAST);
    boundary = tick && (scan_q == '0);
    commit   = boundary && pending_q;
    src_dig  = commit ? sh_dig_q : act_dig_q;
    src_en   = commit ? sh_en_q  : act_en_q;
    src_dp   = commit ? sh_dp_q  : act_dp_q;
    src_bl   = commit ? sh_bl_q  : act_bl_q;
  end

`ifdef LED7_LZ_BLANK_EN
  // Walk from the most significant digit down; a digit stays suppressed while
  // every digit at or above it is disabled or zero.
  always_comb begin
    logic run;
    run  = 1'b1;
    supp = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      run     = run & (~src_en[k] | (src_dig[4*k +: 4] == 4'h0));
      supp[k] = run;
    end
  end
`else
  assign supp = '0;
`endif

  // Slot decode
  always_comb begin
    sel_nib  = '0;
    sel_en   = 1'b0;
    sel_dp   = 1'b0;
    sel_bl   = 1'b0;
    sel_supp = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (scan_q == SW'(k)) begin
        sel_nib  = src_dig[4*k +: 4];
        sel_en   = src_en[k];
        sel_dp   = src_dp[k];
        sel_bl   = src_bl[k];
        sel_supp = supp[k];
      end
    end
    sel_hex  = hex_seg(sel_nib);
    slot_seg = 8'hFF;
    if (sel_en && !(blink_ph_q && sel_bl)) begin
      slot_seg = {(sel_supp ? 7'h7F : sel_hex[7:1]), ~sel_dp};
    end
  end

  // Next state
  always_comb begin
    presc_d     = tick ? '0 : presc_q + 1'b1;
    scan_d      = scan_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    sh_dig_d    = sh_dig_q;
    sh_en_d     = sh_en_q;
    sh_dp_d     = sh_dp_q;
    sh_bl_d     = sh_bl_q;
    act_dig_d   = act_dig_q;
    act_en_d    = act_en_q;
    act_dp_d    = act_dp_q;
    act_bl_d    = act_bl_q;
    pending_d   = pending_q;
    seg_d       = seg_q;
    an_d        = an_q;
    frame_d     = boundary;

    if (tick) begin
      scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
      seg_d  = slot_seg;
      an_d   = ~(AN_ONE << scan_q);
    end

    if (boundary) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    if (commit) begin
      act_dig_d = sh_dig_q;
      act_en_d  = sh_en_q;
      act_dp_d  = sh_dp_q;
      act_bl_d  = sh_bl_q;
      pending_d = 1'b0;
    end

    // A load on the committing edge overrides the pending clear: the data
    // captured now waits for the next frame.
    if (bus.load_i) begin
      sh_dig_d  = bus.digits_i;
      sh_en_d   = bus.digit_en_i;
      sh_dp_d   = bus.dp_i;
      sh_bl_d   = bus.blink_i;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q     <= '0;
      scan_q      <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      sh_dig_q    <= '0;
      sh_en_q     <= '0;
      sh_dp_q     <= '0;
      sh_bl_q     <= '0;
      act_dig_q   <= '0;
      act_en_q    <= '0;
      act_dp_q    <= '0;
      act_bl_q    <= '0;
      pending_q   <= 1'b0;
      seg_q       <= 8'hFF;
      an_q        <= '1;
      frame_q     <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      scan_q      <= scan_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      sh_dig_q    <= sh_dig_d;
      sh_en_q     <= sh_en_d;
      sh_dp_q     <= sh_dp_d;
      sh_bl_q     <= sh_bl_d;
      act_dig_q   <= act_dig_d;
      act_en_q    <= act_en_d;
      act_dp_q    <= act_dp_d;
      act_bl_q    <= act_bl_d;
      pending_q   <= pending_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      frame_q     <= frame_d;
    end
  end

  assign bus.led7_seg_o = seg_q;
  assign bus.led7_an_o  = an_q;
  assign bus.frame_o    = frame_q;

endmodule

// File: tb/tb_led7_scan_mux.sv
// tb/tb_led7_scan_mux.sv - self-checking bench for led7_scan_mux
module tb_led7_scan_mux;

  localparam int N = 8;
  localparam int P = 2;
  localparam int B = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  led7_scan_mux_if #(.NUM_DIGITS(N)) bus ();

  led7_scan_mux #(
    .NUM_DIGITS(N),
    .PRESCALE  (P),
    .BLINK_DIV (B)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model
  logic [7:0] seg_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                               8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  function automatic logic [7:0] model_decode(input logic [4*N-1:0] dig, input logic [N-1:0] en,
                                              input logic [N-1:0] dp, input logic [N-1:0] bl,
                                              input int slot, input int phase);
    logic [7:0] s;
    if (!en[slot]) return 8'hFF;
    if (phase == 1 && bl[slot]) return 8'hFF;
    s = seg_tab[dig[4*slot +: 4]];
`ifdef LED7_LZ_BLANK_EN
    begin
      int top;
      top = -1;
      for (int k = 0; k < N; k++)
        if (en[k] && dig[4*k +: 4] != 4'h0) top = k;
      if (slot > 0 && slot > top) s = 8'hFF;
    end
`endif
    s[0] = ~dp[slot];
    return s;
  endfunction

  int             m_c = 0;
  bit             m_pend = 0;
  logic [4*N-1:0] m_sh_dig = '0, m_act_dig = '0;
  logic [N-1:0]   m_sh_en = '0, m_sh_dp = '0, m_sh_bl = '0;
  logic [N-1:0]   m_act_en = '0, m_act_dp = '0, m_act_bl = '0;
  logic [7:0]     exp_seg = 8'hFF;
  logic [N-1:0]   exp_an = '1;
  logic           exp_frame = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_c = 0; m_pend = 0;
        m_sh_dig = '0; m_sh_en = '0; m_sh_dp = '0; m_sh_bl = '0;
        m_act_dig = '0; m_act_en = '0; m_act_dp = '0; m_act_bl = '0;
        exp_seg = 8'hFF; exp_an = '1; exp_frame = 1'b0;
      end else begin
        exp_frame = 1'b0;
        if (m_c % P == P - 1) begin
          int t, slot, f, ph;
          t    = m_c / P;
          slot = t % N;
          f    = t / N;
          if (slot == 0) begin
            exp_frame = 1'b1;
            if (m_pend) begin
              m_act_dig = m_sh_dig; m_act_en = m_sh_en; m_act_dp = m_sh_dp; m_act_bl = m_sh_bl;
              m_pend = 0;
            end
            ph = (f / B) % 2;
          end else begin
            ph = ((f + 1) / B) % 2;
          end
          exp_seg = model_decode(m_act_dig, m_act_en, m_act_dp, m_act_bl, slot, ph);
          exp_an  = ~(N'(1) << slot);
        end
        if (bus.load_i) begin
          m_sh_dig = bus.digits_i; m_sh_en = bus.digit_en_i;
          m_sh_dp = bus.dp_i; m_sh_bl = bus.blink_i;
          m_pend = 1;
        end
        m_c++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check8("model_seg", bus.led7_seg_o, exp_seg);
      check8("model_an", bus.led7_an_o, exp_an);
      check8("model_frame", {7'b0, bus.frame_o}, {7'b0, exp_frame});
    end
  end

  // Stimulus helpers
  task automatic wait_frame();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.frame_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.frame_o !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_frame: got no frame pulse, expected one within 200 cycles");
    end
  endtask

  task automatic drive_load(input logic [4*N-1:0] dig, input logic [N-1:0] en,
                            input logic [N-1:0] dp, input logic [N-1:0] bl);
    bus.digits_i = dig; bus.digit_en_i = en; bus.dp_i = dp; bus.blink_i = bl;
    bus.load_i = 1'b1;
    @(negedge clk);
    bus.load_i = 1'b0;
  endtask

  task automatic load_commit(input logic [4*N-1:0] dig, input logic [N-1:0] en,
                             input logic [N-1:0] dp, input logic [N-1:0] bl);
    wait_frame();
    drive_load(dig, en, dp, bl);
    wait_frame();
  endtask

  logic [7:0] scan_exp  [8] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F};
  logic [7:0] blink_exp [6] = '{8'h49, 8'h49, 8'hFF, 8'hFF, 8'h49, 8'h49};
`ifdef LED7_LZ_BLANK_EN
  logic [7:0] lz_exp    [8] = '{8'h49, 8'h03, 8'h9F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] zero_exp  [8] = '{8'h03, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`else
  logic [7:0] lz_exp    [8] = '{8'h49, 8'h03, 8'h9F, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03};
  logic [7:0] zero_exp  [8] = '{8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03};
`endif

  initial begin
    int frames;
    bus.digits_i = '0; bus.digit_en_i = '0; bus.dp_i = '0; bus.blink_i = '0; bus.load_i = 1'b0;
    #1 rst_n = 1'b0;

    // Reset and first tick
    repeat (3) @(negedge clk);
    check8("reset_seg", bus.led7_seg_o, 8'hFF);
    check8("reset_an", bus.led7_an_o, 8'hFF);
    check8("reset_frame", {7'b0, bus.frame_o}, 8'h00);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check8("pre_tick_an", bus.led7_an_o, 8'hFF);
    @(negedge clk);
    check8("first_tick_an", bus.led7_an_o, 8'hFE);
    check8("first_tick_frame", {7'b0, bus.frame_o}, 8'h01);
    check8("first_tick_seg", bus.led7_seg_o, 8'hFF);

    // Scan order and frame pulse
    load_commit(32'h76543210, 8'hFF, 8'h00, 8'h00);
    frames = 0;
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 2; c++) begin
        check8("scan_seg", bus.led7_seg_o, scan_exp[s]);
        check8("scan_an", bus.led7_an_o, ~(8'h01 << s));
        if (bus.frame_o) frames++;
        @(negedge clk);
      end
    end
    check8("frame_pulses_per_16", 8'(frames), 8'd1);

    // Tear-free update: load while slot 3 shown
    repeat (6) @(negedge clk);
    check8("slot3_an", bus.led7_an_o, 8'hF7);
    drive_load(32'h88888888, 8'hFF, 8'h00, 8'h00);
    @(negedge clk);
    for (int s = 4; s < 8; s++) begin
      check8("tear_old_seg", bus.led7_seg_o, scan_exp[s]);
      repeat (2) @(negedge clk);
    end
    check8("tear_new_frame", {7'b0, bus.frame_o}, 8'h01);
    check8("tear_new_seg", bus.led7_seg_o, 8'h01);
    // Load on the frame-boundary edge
    repeat (15) @(negedge clk);
    drive_load(32'h33333333, 8'hFF, 8'h00, 8'h00);
    check8("bnd_load_frame", {7'b0, bus.frame_o}, 8'h01);
    check8("bnd_load_seg_old", bus.led7_seg_o, 8'h01);
    repeat (16) @(negedge clk);
    check8("bnd_load_seg_new", bus.led7_seg_o, 8'h0D);

    // Enable and dp
    load_commit(32'h00000210, 8'hFE, 8'h04, 8'h00);
    check8("en_slot0", bus.led7_seg_o, 8'hFF);
    repeat (2) @(negedge clk);
    check8("en_slot1", bus.led7_seg_o, 8'h9F);
    repeat (2) @(negedge clk);
    check8("dp_slot2", bus.led7_seg_o, 8'h24);

    // Mid-operation reset with a load still pending
    drive_load(32'hFFFFFFFF, 8'hFF, 8'h00, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    check8("midrst_seg", bus.led7_seg_o, 8'hFF);
    check8("midrst_an", bus.led7_an_o, 8'hFF);
    check8("midrst_frame", {7'b0, bus.frame_o}, 8'h00);
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_frame();
    check8("midrst_no_commit_seg", bus.led7_seg_o, 8'hFF);

    // Blink: committed in frame 1, observed over frames 3..8
    drive_load(32'h00005000, 8'hFF, 8'h00, 8'h08);
    wait_frame();
    wait_frame();
    for (int i = 0; i < 6; i++) begin
      wait_frame();
      check8("blink_slot0", bus.led7_seg_o, 8'h03);
      repeat (6) @(negedge clk);
      check8("blink_slot3", bus.led7_seg_o, blink_exp[i]);
    end

    // Leading zeros
    load_commit(32'h00000105, 8'hFF, 8'h00, 8'h00);
    for (int s = 0; s < 8; s++) begin
      check8("lz_seg", bus.led7_seg_o, lz_exp[s]);
      repeat (2) @(negedge clk);
    end
    load_commit(32'h00000000, 8'hFF, 8'h00, 8'h00);
    for (int s = 0; s < 8; s++) begin
      check8("zero_seg", bus.led7_seg_o, zero_exp[s]);
      repeat (2) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
